// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - RV32I integer ALU issue/writeback controller driving an external combinational alu
// Optional LUI decode is enabled by defining ALU_ISSUE_LUI_EN.

`ifndef ALU_VH
`define ALU_VH
`define ALUOP_WIDTH 4
`define ALUOP_ADD  4'd0
`define ALUOP_SUB  4'd1
`define ALUOP_SLL  4'd2
`define ALUOP_SLT  4'd3
`define ALUOP_SLTU 4'd4
`define ALUOP_XOR  4'd5
`define ALUOP_SRL  4'd6
`define ALUOP_SRA  4'd7
`define ALUOP_OR   4'd8
`define ALUOP_AND  4'd9
`endif

module alu_issue (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    instr_valid,
   output logic                    instr_ready,
   input  logic [31:0]             instr,
   output logic [`ALUOP_WIDTH-1:0] alu_op,
   output logic [31:0]             alu_rs1,
   output logic [31:0]             alu_rs2,
   input  logic [31:0]             alu_rd,
   output logic                    wb_valid,
   output logic [4:0]              wb_idx,
   output logic [31:0]             wb_data,
   output logic                    illegal,
   input  logic [4:0]              dbg_idx,
   output logic [31:0]             dbg_data
);

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] F7_ZERO    = 7'h00;
   localparam logic [6:0] F7_ALT     = 7'h20;

   state_t                    state;
   state_t                    state_nxt;
   logic [31:0]               regs [0:31];
   logic [4:0]                rd_q;
   logic                      accept;

   logic [6:0]                opcode;
   logic [2:0]                funct3;
   logic [6:0]                funct7;
   logic [4:0]                rs1_idx;
   logic [4:0]                rs2_idx;
   logic [31:0]               rs1_val;
   logic [31:0]               rs2_val;

   logic                      dec_legal;
   logic [`ALUOP_WIDTH-1:0]   dec_op;
   logic [31:0]               dec_rs1;
   logic [31:0]               dec_rs2;

   assign opcode  = instr[6:0];
   assign funct3  = instr[14:12];
   assign funct7  = instr[31:25];
   assign rs1_idx = instr[19:15];
   assign rs2_idx = instr[24:20];

   // x0 is never written, but the explicit zero keeps reads correct regardless
   assign rs1_val  = (rs1_idx == 5'd0) ? 32'd0 : regs[rs1_idx];
   assign rs2_val  = (rs2_idx == 5'd0) ? 32'd0 : regs[rs2_idx];
   assign dbg_data = (dbg_idx == 5'd0) ? 32'd0 : regs[dbg_idx];

   assign accept = instr_valid && (state == S_IDLE);

   function automatic logic [`ALUOP_WIDTH-1:0] f3_to_op(input logic [2:0] f3);
      case (f3)
         3'b000:  f3_to_op = `ALUOP_ADD;
         3'b001:  f3_to_op = `ALUOP_SLL;
         3'b010:  f3_to_op = `ALUOP_SLT;
         3'b011:  f3_to_op = `ALUOP_SLTU;
         3'b100:  f3_to_op = `ALUOP_XOR;
         3'b101:  f3_to_op = `ALUOP_SRL;
         3'b110:  f3_to_op = `ALUOP_OR;
         default: f3_to_op = `ALUOP_AND;
      endcase
   endfunction

   always_comb begin
      dec_legal = 1'b0;
      dec_op    = `ALUOP_ADD;
      dec_rs1   = rs1_val;
      dec_rs2   = rs2_val;
      case (opcode)
         OPC_OP: begin
            dec_op = f3_to_op(funct3);
            if (funct7 == F7_ZERO) begin
               dec_legal = 1'b1;
            end else if (funct7 == F7_ALT) begin
               if (funct3 == 3'b000) begin
                  dec_legal = 1'b1;
                  dec_op    = `ALUOP_SUB;
               end else if (funct3 == 3'b101) begin
                  dec_legal = 1'b1;
                  dec_op    = `ALUOP_SRA;
               end
            end
         end
         OPC_OP_IMM: begin
            dec_op  = f3_to_op(funct3);
            dec_rs2 = {{20{instr[31]}}, instr[31:20]};
            if (funct3 == 3'b001 || funct3 == 3'b101) begin
               // shift immediates: upper bits select SRL/SRA and must be otherwise clean
               dec_rs2 = {27'd0, instr[24:20]};
               if (funct7 == F7_ZERO) begin
                  dec_legal = 1'b1;
               end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                  dec_legal = 1'b1;
                  dec_op    = `ALUOP_SRA;
               end
            end else begin
               dec_legal = 1'b1;
            end
         end
`ifdef ALU_ISSUE_LUI_EN
         OPC_LUI: begin
            dec_legal = 1'b1;
            dec_op    = `ALUOP_ADD;
            dec_rs1   = 32'd0;
            dec_rs2   = {instr[31:12], 12'd0};
         end
`endif
         default: dec_legal = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (accept && dec_legal) state_nxt = S_EXEC;
         S_EXEC:  state_nxt = S_WB;
         S_WB:    state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      instr_ready = (state == S_IDLE);
      wb_valid    = (state == S_WB);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_op  <= `ALUOP_ADD;
         alu_rs1 <= 32'd0;
         alu_rs2 <= 32'd0;
         rd_q    <= 5'd0;
         wb_data <= 32'd0;
         wb_idx  <= 5'd0;
         illegal <= 1'b0;
      end else begin
         illegal <= accept && !dec_legal;
         if (accept && dec_legal) begin
            alu_op  <= dec_op;
            alu_rs1 <= dec_rs1;
            alu_rs2 <= dec_rs2;
            rd_q    <= instr[11:7];
         end
         if (state == S_EXEC) begin
            wb_data <= alu_rd;
            wb_idx  <= rd_q;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            regs[i] <= 32'd0;
         end
      end else if (state == S_WB && wb_idx != 5'd0) begin
         regs[wb_idx] <= wb_data;
      end
   end

endmodule
